// File: rtl/ins_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction fetch slice: word widths, reset PC
// default, fetch FSM state encoding, buffer entry layout, an address
// alignment helper and the canonical NOP word.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int          INST_W       = 32;
    localparam int          ADDR_W       = 32;
    localparam int          ENTRY_W      = ADDR_W + INST_W;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_RUN   = 2'b01,
        S_FLUSH = 2'b10
    } fetch_state_e;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] instr;
    } fetch_entry_t;

    // Instruction fetches are always word aligned.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ins_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// ins_fetch_unit_if
// Bundles the instruction-memory read bus and the decode-side handshake of
// the fetch unit.
//   master : fetch unit side (drives mem_read/mem_address, inst_*)
//   slave  : environment side (memory + decode stage + branch redirect)
// Signals:
//   mem_read, mem_address, mem_readdata, mem_busywait : memory read port
//   redirect, redirect_pc                            : taken branch/jump
//   inst_valid, inst_out, inst_pc, inst_ready        : decode handshake
// ---------------------------------------------------------------------------
interface ins_fetch_unit_if
    import cpu_pkg::*;
;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic [INST_W-1:0] mem_readdata;
    logic              mem_busywait;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output mem_read, mem_address, inst_valid, inst_out, inst_pc,
        input  mem_readdata, mem_busywait, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_read, mem_address, inst_valid, inst_out, inst_pc,
        output mem_readdata, mem_busywait, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/ins_fetch_unit_fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// DEPTH-entry first-word-fall-through FIFO of {pc, instr}.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_flush      : synchronous clear (wins over push/pop)
//   i_push       : write i_push_data at the tail
//   i_pop        : drop the head entry
//   o_head       : head entry, all zeros while empty
//   o_count      : number of valid entries (0..DEPTH)
// Push and pop in the same cycle are both honoured, including when full.
// ---------------------------------------------------------------------------
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  fetch_entry_t           i_push_data,
    input  logic                   i_pop,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_push_en;
    logic w_pop_en;

    assign w_empty   = (r_count == {(PW+1){1'b0}});
    assign w_full    = (r_count == (PW+1)'(DEPTH));
    assign w_pop_en  = i_pop && !w_empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_push_en = i_push && (!w_full || w_pop_en);

    // Zero the visible head while empty so flushed words never leak out.
    assign o_head  = w_empty ? fetch_entry_t'({ENTRY_W{1'b0}}) : r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= fetch_entry_t'({ENTRY_W{1'b0}});
            end
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {(PW+1){1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {(PW+1){1'b0}};
        end else begin
            if (w_push_en) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1'b1);
            end else begin
                r_wr_ptr        <= r_wr_ptr;
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + PW'(1'b1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + (PW+1)'(1'b1);
                2'b01:   r_count <= r_count - (PW+1)'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ins_fetch_unit.sv
// ---------------------------------------------------------------------------
// ins_fetch_unit
// Initiator side of the instruction-memory read interface. Owns the PC,
// issues word fetches, buffers returned instructions for IF/ID and handles
// memory stalls, decode back-pressure and branch/jump redirects.
// Ports:
//   clock    : system clock, all state on posedge
//   reset_n  : asynchronous active-low reset
//   bus      : ins_fetch_unit_if.master (memory read port, redirect input,
//              decode handshake)
// Parameters:
//   RESET_PC : PC loaded on reset
//   DEPTH    : instruction buffer entries (power of two, >= 2)
// ---------------------------------------------------------------------------
module ins_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    ins_fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_outstanding;

    logic              w_mem_read;
    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic              w_inst_valid;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_occ;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_data;

    // Pop path is combinational from inst_ready so a full buffer can refill
    // in the same cycle it drains.
    assign w_inst_valid = (w_count != {CW{1'b0}});
    assign w_pop        = w_inst_valid && bus.inst_ready;

    // Slots already claimed: buffered entries plus the fetch in flight,
    // less the entry leaving now. Issuing only below DEPTH reserves a slot
    // for every accepted request.
    assign w_occ      = {1'b0, w_count} + {{CW{1'b0}}, r_outstanding}
                      - {{CW{1'b0}}, w_pop};
    assign w_mem_read = (r_state == S_RUN) && (w_occ < (CW+1)'(DEPTH));
    assign w_accept   = w_mem_read && !bus.mem_busywait;

    // A response landing on a redirect edge belongs to the old stream; a
    // request accepted on the redirect edge never sets r_outstanding.
    assign w_push      = r_outstanding && !bus.redirect;
    assign w_push_data = '{pc: r_req_pc, instr: bus.mem_readdata};

    // Next-state logic; redirect overrides every state and re-enters flush.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect) begin
            w_state_nxt = S_FLUSH;
        end else begin
            case (r_state)
                S_BOOT:  w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = S_RUN;
                S_FLUSH: w_state_nxt = S_RUN;
                default: w_state_nxt = S_BOOT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC: redirect target first, otherwise advance only on acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= align_word(RESET_PC);
        end else if (bus.redirect) begin
            r_pc <= align_word(bus.redirect_pc);
        end else if (w_accept) begin
            r_pc <= r_pc + 32'd4;
        end else begin
            r_pc <= r_pc;
        end
    end

    // In-flight fetch tracking and the address it was issued for.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_outstanding <= 1'b0;
            r_req_pc      <= {ADDR_W{1'b0}};
        end else begin
            r_outstanding <= w_accept && !bus.redirect;
            if (w_accept) begin
                r_req_pc <= r_pc;
            end else begin
                r_req_pc <= r_req_pc;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_fetch_buffer (
        .clk         (clock),
        .rst_n       (reset_n),
        .i_flush     (bus.redirect),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign bus.mem_read    = w_mem_read;
    assign bus.mem_address = r_pc;
    assign bus.inst_valid  = w_inst_valid;
    assign bus.inst_out    = w_head.instr;
    assign bus.inst_pc     = w_head.pc;

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Directed bench for ins_fetch_unit. Instance A starts at PC 0 and takes
// all directed stimulus; instance B starts at FFFF_FFF8 with a free-running
// memory and decode. Memory stubs return (address ^ 32'hDEAD_0000) in the
// cycle after acceptance.
module tb_ins_fetch_unit;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    ins_fetch_unit_if ifa ();
    ins_fetch_unit_if ifb ();

    ins_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifa.master)
    );

    ins_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifb.master)
    );

    logic [31:0] last_a;
    logic [31:0] last_b;

    always @(posedge clock) begin
        if (ifa.mem_read && !ifa.mem_busywait) last_a <= ifa.mem_address;
        if (ifb.mem_read && !ifb.mem_busywait) last_b <= ifb.mem_address;
    end

    assign ifa.mem_readdata = last_a ^ 32'hDEAD_0000;
    assign ifb.mem_readdata = last_b ^ 32'hDEAD_0000;

    int n_cmp    = 0;
    int n_bad    = 0;
    int consumed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Count a decode handshake just before the edge, then settle after it.
    task automatic tick();
        @(negedge clock);
        if (ifa.inst_valid && ifa.inst_ready) consumed++;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n          = 1'b0;
        ifa.mem_busywait = 1'b0;
        ifa.redirect     = 1'b0;
        ifa.redirect_pc  = 32'h0;
        ifa.inst_ready   = 1'b1;
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        consumed = 0;
    endtask

    initial begin
        ifa.mem_busywait = 1'b0;
        ifa.redirect     = 1'b0;
        ifa.redirect_pc  = 32'h0;
        ifa.inst_ready   = 1'b1;
        ifb.mem_busywait = 1'b0;
        ifb.redirect     = 1'b0;
        ifb.redirect_pc  = 32'h0;
        ifb.inst_ready   = 1'b1;

        // ---- reset values ----
        #1 reset_n = 1'b0;
        #2;
        chk("rst_mem_read",   {31'd0, ifa.mem_read},   32'h0);
        chk("rst_mem_addr",   ifa.mem_address,          32'h0);
        chk("rst_inst_valid", {31'd0, ifa.inst_valid}, 32'h0);
        chk("rst_inst_out",   ifa.inst_out,             32'h0);
        chk("rst_inst_pc",    ifa.inst_pc,              32'h0);
        chk("rst_b_mem_addr", ifb.mem_address,          32'hFFFF_FFF8);

        // ---- streaming, first-valid latency, B wrap-around ----
        @(posedge clock);
        #1 reset_n = 1'b1;
        chk("boot_mem_read",   {31'd0, ifa.mem_read}, 32'h0);
        chk("boot_b_mem_read", {31'd0, ifb.mem_read}, 32'h0);
        tick();
        chk("s1_mem_read",   {31'd0, ifa.mem_read},   32'h1);
        chk("s1_addr",       ifa.mem_address,          32'h0);
        chk("s1_b_addr",     ifb.mem_address,          32'hFFFF_FFF8);
        chk("s1_valid",      {31'd0, ifa.inst_valid}, 32'h0);
        tick();
        chk("s2_addr",       ifa.mem_address,          32'h4);
        chk("s2_valid",      {31'd0, ifa.inst_valid}, 32'h0);
        chk("s2_b_addr",     ifb.mem_address,          32'hFFFF_FFFC);
        tick();
        chk("s3_addr",       ifa.mem_address,          32'h8);
        chk("s3_valid",      {31'd0, ifa.inst_valid}, 32'h1);
        chk("s3_pc",         ifa.inst_pc,              32'h0);
        chk("s3_out",        ifa.inst_out,             32'hDEAD_0000);
        chk("s3_b_addr",     ifb.mem_address,          32'h0000_0000);
        chk("s3_b_pc",       ifb.inst_pc,              32'hFFFF_FFF8);
        chk("s3_b_out",      ifb.inst_out,             32'h2152_FFF8);
        tick();
        chk("s4_pc",         ifa.inst_pc,              32'h4);
        chk("s4_out",        ifa.inst_out,             32'hDEAD_0004);
        chk("s4_b_pc",       ifb.inst_pc,              32'hFFFF_FFFC);
        chk("s4_b_out",      ifb.inst_out,             32'h2152_FFFC);
        tick();
        chk("s5_pc",         ifa.inst_pc,              32'h8);
        chk("s5_out",        ifa.inst_out,             32'hDEAD_0008);
        chk("s5_b_pc",       ifb.inst_pc,              32'h0);
        chk("s5_b_out",      ifb.inst_out,             32'hDEAD_0000);
        // async reset mid-cycle
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid",      {31'd0, ifa.inst_valid}, 32'h0);
        chk("ar_mem_read",   {31'd0, ifa.mem_read},   32'h0);
        chk("ar_b_valid",    {31'd0, ifb.inst_valid}, 32'h0);
        chk("ar_b_mem_read", {31'd0, ifb.mem_read},   32'h0);

        // ---- busywait on 0x4 for three cycles ----
        do_reset();
        tick();
        tick();
        chk("bw_addr0", ifa.mem_address, 32'h4);
        ifa.mem_busywait = 1'b1;
        tick();
        chk("bw1_read",  {31'd0, ifa.mem_read},   32'h1);
        chk("bw1_addr",  ifa.mem_address,          32'h4);
        chk("bw1_pc",    ifa.inst_pc,              32'h0);
        chk("bw1_valid", {31'd0, ifa.inst_valid}, 32'h1);
        tick();
        chk("bw2_read",  {31'd0, ifa.mem_read},   32'h1);
        chk("bw2_addr",  ifa.mem_address,          32'h4);
        chk("bw2_valid", {31'd0, ifa.inst_valid}, 32'h0);
        tick();
        chk("bw3_read",  {31'd0, ifa.mem_read},   32'h1);
        chk("bw3_addr",  ifa.mem_address,          32'h4);
        chk("bw3_valid", {31'd0, ifa.inst_valid}, 32'h0);
        ifa.mem_busywait = 1'b0;
        tick();
        chk("bw4_addr",  ifa.mem_address,          32'h8);
        chk("bw4_valid", {31'd0, ifa.inst_valid}, 32'h0);
        tick();
        chk("bw5_pc",    ifa.inst_pc,              32'h4);
        chk("bw5_out",   ifa.inst_out,             32'hDEAD_0004);
        tick();
        chk("bw6_pc",    ifa.inst_pc,              32'h8);

        // ---- decode back-pressure fills the buffer ----
        do_reset();
        ifa.inst_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("bp3_read",  {31'd0, ifa.mem_read},   32'h0);
        chk("bp3_addr",  ifa.mem_address,          32'h8);
        tick();
        chk("bp4_valid", {31'd0, ifa.inst_valid}, 32'h1);
        chk("bp4_pc",    ifa.inst_pc,              32'h0);
        chk("bp4_read",  {31'd0, ifa.mem_read},   32'h0);
        tick();
        chk("bp5_pc",    ifa.inst_pc,              32'h0);
        chk("bp5_out",   ifa.inst_out,             32'hDEAD_0000);
        chk("bp5_read",  {31'd0, ifa.mem_read},   32'h0);
        chk("bp5_addr",  ifa.mem_address,          32'h8);
        ifa.inst_ready = 1'b1;
        #1;
        chk("bp_rel_read", {31'd0, ifa.mem_read}, 32'h1);
        tick();
        chk("bp6_pc",    ifa.inst_pc,              32'h4);
        chk("bp6_out",   ifa.inst_out,             32'hDEAD_0004);
        chk("bp6_addr",  ifa.mem_address,          32'hC);
        tick();
        chk("bp7_pc",    ifa.inst_pc,              32'h8);
        chk("bp7_out",   ifa.inst_out,             32'hDEAD_0008);

        // ---- redirect while the fetch of 0x8 is in flight ----
        do_reset();
        tick();
        tick();
        tick();
        tick();
        chk("rd0_pc", ifa.inst_pc, 32'h4);
        ifa.redirect    = 1'b1;
        ifa.redirect_pc = 32'h0000_0103;
        tick();
        ifa.redirect = 1'b0;
        chk("rd1_valid", {31'd0, ifa.inst_valid}, 32'h0);
        chk("rd1_read",  {31'd0, ifa.mem_read},   32'h0);
        chk("rd1_addr",  ifa.mem_address,          32'h100);
        chk("rd1_out",   ifa.inst_out,             32'h0);
        tick();
        chk("rd2_read",  {31'd0, ifa.mem_read},   32'h1);
        chk("rd2_addr",  ifa.mem_address,          32'h100);
        chk("rd2_valid", {31'd0, ifa.inst_valid}, 32'h0);
        tick();
        chk("rd3_valid", {31'd0, ifa.inst_valid}, 32'h0);
        tick();
        chk("rd4_valid", {31'd0, ifa.inst_valid}, 32'h1);
        chk("rd4_pc",    ifa.inst_pc,              32'h100);
        chk("rd4_out",   ifa.inst_out,             32'hDEAD_0100);

        // ---- redirect coinciding with a pop from a full buffer ----
        do_reset();
        ifa.inst_ready = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("rp0_valid", {31'd0, ifa.inst_valid}, 32'h1);
        chk("rp0_pc",    ifa.inst_pc,              32'h0);
        ifa.inst_ready  = 1'b1;
        ifa.redirect    = 1'b1;
        ifa.redirect_pc = 32'h0000_0200;
        tick();
        ifa.redirect = 1'b0;
        chk("rp1_valid",    {31'd0, ifa.inst_valid}, 32'h0);
        chk("rp1_consumed", consumed,                 32'd1);
        tick();
        chk("rp2_valid",    {31'd0, ifa.inst_valid}, 32'h0);
        chk("rp2_read",     {31'd0, ifa.mem_read},   32'h1);
        chk("rp2_addr",     ifa.mem_address,          32'h200);
        tick();
        tick();
        chk("rp4_pc",       ifa.inst_pc,              32'h200);
        chk("rp4_consumed", consumed,                 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
